// File: rtl/gate_bist_engine.sv
// rtl/gate_bist_engine.sv - exhaustive-vector self-test driver/checker for N-input gate cells
// Optional first-failure capture ports enabled by GATE_BIST_FAIL_LOG_EN.
module gate_bist_engine #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      func,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count
`ifdef GATE_BIST_FAIL_LOG_EN
  ,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE     = 1;
  localparam logic [N_IN:0]   ERR_ONE     = 1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      func_q, func_d;
  logic [N_IN:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic            golden;
`ifdef GATE_BIST_FAIL_LOG_EN
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
`endif

  always_comb begin
    golden = 1'b0;
    case (func_q)
      2'b00:   golden = |idx_q;
      2'b01:   golden = &idx_q;
      2'b10:   golden = ^idx_q;
      default: golden = ~|idx_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    err_d   = err_q;
    pass_d  = pass_q;
`ifdef GATE_BIST_FAIL_LOG_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d  = func;
          err_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_DRIVE;
`ifdef GATE_BIST_FAIL_LOG_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
`endif
        end
      end
      ST_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (dut_out != golden) begin
          err_d = err_q + ERR_ONE;
`ifdef GATE_BIST_FAIL_LOG_EN
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = idx_q;
          end
`endif
        end
        // pass is resolved here so it is already valid during the DONE cycle
        if (idx_q == IDX_LAST) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      func_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef GATE_BIST_FAIL_LOG_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef GATE_BIST_FAIL_LOG_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
`endif
    end
  end

  assign dut_in    = idx_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef GATE_BIST_FAIL_LOG_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_bist_engine.sv
// tb/tb_gate_bist_engine.sv - scoreboard bench for gate_bist_engine
// Fail-log checks are active when GATE_BIST_FAIL_LOG_EN is defined.
module tb_gate_bist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, dut_out, busy, done, pass;
  logic [1:0] func;
  logic [2:0] dut_in;
  logic [3:0] err_count;
`ifdef GATE_BIST_FAIL_LOG_EN
  logic       fail_valid;
  logic [2:0] fail_vec;
`endif

  logic       b_start, b_out, b_busy, b_done, b_pass;
  logic [1:0] b_func;
  logic [1:0] b_in;
  logic [2:0] b_err;
`ifdef GATE_BIST_FAIL_LOG_EN
  logic       b_fail_valid;
  logic [1:0] b_fail_vec;
`endif

  int model_sel;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cell models: 0 correct OR, 1 stuck-at-0, 2 correct AND
  always_comb begin
    dut_out = 1'b0;
    case (model_sel)
      0:       dut_out = |dut_in;
      1:       dut_out = 1'b0;
      default: dut_out = &dut_in;
    endcase
  end
  assign b_out = &b_in;

  gate_bist_engine #(.N_IN(3), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_BIST_FAIL_LOG_EN
    , .fail_valid(fail_valid), .fail_vec(fail_vec)
`endif
  );

  gate_bist_engine #(.N_IN(2), .SETTLE(1)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .start(b_start), .func(b_func), .dut_in(b_in),
    .dut_out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err)
`ifdef GATE_BIST_FAIL_LOG_EN
    , .fail_valid(b_fail_valid), .fail_vec(b_fail_vec)
`endif
  );

  typedef struct {
    int err;
    int pass;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vec_q[$];
  int   done_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t mon_e;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // current cycle number at a negedge is cyc+1; start seen at edge k => done in cycle k+25
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        check_val("vec_expected", int'(vec_q.size() > 0), 1);
        if (vec_q.size() > 0) check_val("dut_in", int'(dut_in), vec_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check_val("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_val("err_count", int'(err_count), mon_e.err);
          check_val("pass", int'(pass), mon_e.pass);
          check_val("done_cycle", cyc + 1, mon_e.done_cyc);
        end
      end
    end
  end

  task automatic push_run(input int k, input int err, input int p);
    exp_t e;
    e.err = err;
    e.pass = p;
    e.done_cyc = k + 25;
    exp_q.push_back(e);
    for (int v = 0; v < 8; v++)
      for (int s = 0; s < 3; s++) vec_q.push_back(v);
  endtask

  task automatic start_run(input logic [1:0] f, input int model, output int k);
    @(negedge clk);
    model_sel = model;
    func = f;
    start = 1'b1;
    k = cyc + 1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && done_cnt < target; i++) @(negedge clk);
    check_val("done_timeout", int'(done_cnt >= target), 1);
  endtask

  int k, dc, bk, bdone;
  int bq[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; func = 2'b00; model_sel = 0;
    b_start = 1'b0; b_func = 2'b00;
    repeat (3) @(negedge clk);
    check_val("rst_dut_in", int'(dut_in), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_pass", int'(pass), 0);
    check_val("rst_err", int'(err_count), 0);
    check_val("rst_b_busy", int'(b_busy), 0);
`ifdef GATE_BIST_FAIL_LOG_EN
    check_val("rst_fail_valid", int'(fail_valid), 0);
`endif
    rst_n = 1'b1;

    // correct OR cell
    start_run(2'b00, 0, k);
    push_run(k, 0, 1);
    @(negedge clk); start = 1'b0;
    wait_done(1);
    @(negedge clk);
    check_val("or_pass_hold", int'(pass), 1);
    check_val("or_busy_idle", int'(busy), 0);
`ifdef GATE_BIST_FAIL_LOG_EN
    check_val("or_fail_valid", int'(fail_valid), 0);
`endif

    // stuck-at-0 cell
    start_run(2'b00, 1, k);
    push_run(k, 7, 0);
    @(negedge clk); start = 1'b0;
    wait_done(2);
    @(negedge clk);
    check_val("sa0_err_hold", int'(err_count), 7);
`ifdef GATE_BIST_FAIL_LOG_EN
    check_val("sa0_fail_valid", int'(fail_valid), 1);
    check_val("sa0_fail_vec", int'(fail_vec), 1);
`endif

    // start held, func toggled mid-run; second run latches NOR at k+26
    start_run(2'b00, 0, k);
    push_run(k, 0, 1);
    push_run(k + 26, 8, 0);
    repeat (10) @(negedge clk);
    func = 2'b11;
    for (int i = 0; i < 100 && (cyc + 1) < k + 27; i++) @(negedge clk);
    check_val("hold_second_busy", int'(busy), 1);
    start = 1'b0;
    wait_done(4);
    repeat (5) @(negedge clk);
    check_val("hold_done_count", done_cnt, 4);

    // reset mid-run at dut_in=3
    start_run(2'b00, 0, k);
    push_run(k, 0, 1);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && dut_in != 3'd3; i++) @(negedge clk);
    check_val("abort_at_vec3", int'(dut_in), 3);
    rst_n = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    check_val("abort_dut_in", int'(dut_in), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_pass", int'(pass), 0);
    check_val("abort_err", int'(err_count), 0);
    rst_n = 1'b1;
    exp_q.delete();
    vec_q.delete();
    repeat (30) @(negedge clk);
    check_val("abort_no_done", done_cnt, dc);
    start_run(2'b00, 0, k);
    push_run(k, 0, 1);
    @(negedge clk); start = 1'b0;
    wait_done(dc + 1);

    // N_IN=2, SETTLE=1, AND cell
    for (int v = 0; v < 4; v++) begin
      bq.push_back(v);
      bq.push_back(v);
    end
    @(negedge clk);
    b_start = 1'b1; b_func = 2'b01;
    bk = cyc + 1;
    bdone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_busy) begin
        check_val("b_vec_expected", int'(bq.size() > 0), 1);
        if (bq.size() > 0) check_val("b_dut_in", int'(b_in), bq.pop_front());
      end
      if (b_done) begin
        bdone++;
        check_val("b_done_cycle", cyc + 1, bk + 9);
        check_val("b_pass", int'(b_pass), 1);
        check_val("b_err", int'(b_err), 0);
      end
    end
    check_val("b_done_count", bdone, 1);
    check_val("b_vec_left", bq.size(), 0);

    check_val("exp_left", exp_q.size(), 0);
    check_val("vec_left", vec_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
